fixp_vec_feeder: RTL

//  Sequential front end for the combinational s7.8 dot-product (multiply-accumulate) unit.

---
 rtl/fixp_vec_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fixp_vec_feeder.sv
// fixp_vec_feeder: serial front end for a combinational fixed-point dot-product unit.
// Packs a valid/ready word stream into a persistent weight vector and an x vector,
// captures the unit's result one cycle after the x vector completes, and returns it
// on a valid/ready output stream.
module fixp_vec_feeder #(
   parameter int DIM   = 2,
   parameter int BITW  = 16,
   parameter int FRACW = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_is_w,
   input  logic [BITW-1:0]            in_data,
   output logic [DIM-1:0][BITW-1:0]   weights_o,
   output logic [DIM-1:0][BITW-1:0]   x_o,
   input  logic [BITW-1:0]            dot_i,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BITW-1:0]            out_data,
   output logic                       w_loaded
);

   // Counter width; a single-element vector still needs a one-bit index.
   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIM - 1);

   // The fraction width is only a format label here; reject nonsensical formats.
   if (FRACW >= BITW || DIM < 1) begin : g_param_check
      $error("fixp_vec_feeder: FRACW must be < BITW and DIM >= 1");
   end

   typedef enum logic [1:0] {
      FILL = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             w_cnt_q, w_cnt_d;
   logic [CW-1:0]             x_cnt_q, x_cnt_d;
   logic                      w_loaded_q, w_loaded_d;
   logic                      out_valid_q, out_valid_d;
   logic [BITW-1:0]           out_data_q, out_data_d;
   logic [DIM-1:0][BITW-1:0]  weights_q, weights_d;
   logic [DIM-1:0][BITW-1:0]  x_q, x_d;
   logic                      accept;

   // Ready depends only on the word class and held state, never on in_valid;
   // weights wait for an x vector to finish, x words wait for a full weight set.
   assign in_ready = (state_q == FILL) && (in_is_w ? (x_cnt_q == '0) : w_loaded_q);
   assign accept   = in_valid && in_ready;

   // Next-state logic: word packing in FILL, result capture in CALC, output handshake in HOLD.
   always_comb begin
      state_d     = state_q;
      w_cnt_d     = w_cnt_q;
      x_cnt_d     = x_cnt_q;
      w_loaded_d  = w_loaded_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      weights_d   = weights_q;
      x_d         = x_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               if (in_is_w) begin
                  weights_d[w_cnt_q] = in_data;
                  if (w_cnt_q == LAST) begin
                     w_cnt_d    = '0;
                     w_loaded_d = 1'b1;
                  end else begin
                     // First word of a reload drops w_loaded until the set is complete.
                     w_cnt_d    = w_cnt_q + 1'b1;
                     w_loaded_d = 1'b0;
                  end
               end else begin
                  x_d[x_cnt_q] = in_data;
                  if (x_cnt_q == LAST) begin
                     x_cnt_d = '0;
                     state_d = CALC;
                  end else begin
                     x_cnt_d = x_cnt_q + 1'b1;
                  end
               end
            end
         end
         CALC: begin
            // Vectors have been stable for a full cycle, so dot_i has settled.
            out_data_d  = dot_i;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and datapath registers; reset clears everything, dropping any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         w_cnt_q     <= '0;
         x_cnt_q     <= '0;
         w_loaded_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         weights_q   <= '0;
         x_q         <= '0;
      end else begin
         state_q     <= state_d;
         w_cnt_q     <= w_cnt_d;
         x_cnt_q     <= x_cnt_d;
         w_loaded_q  <= w_loaded_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         weights_q   <= weights_d;
         x_q         <= x_d;
      end
   end

   assign weights_o = weights_q;
   assign x_o       = x_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign w_loaded  = w_loaded_q;

endmodule
